// File: rtl/dds_cmd_pkg.sv
// dds_cmd_pkg: shared definitions for the DDS update sequencer.
//   - field widths of a DDS update request
//   - dest-sel codes carried in bits [63:60] of every command word
//   - sequencer FSM state type
//   - command word packing helpers, one per word format
package dds_cmd_pkg;

  localparam int FREQ_W    = 48;
  localparam int AMP_W     = 14;
  localparam int PHASE_W   = 14;
  localparam int SEL_W     = 4;
  localparam int CMD_W     = 64;
  localparam int MAX_WORDS = 3;

  localparam logic [SEL_W-1:0] DDS_SEL_FAP = 4'h0;  // amp + phase + freq[47:16]
  localparam logic [SEL_W-1:0] DDS_SEL_F48 = 4'h1;  // full 48-bit freq
  localparam logic [SEL_W-1:0] DDS_SEL_AF  = 4'h2;  // amp + freq[47:2]
  localparam logic [SEL_W-1:0] DDS_SEL_PF  = 4'h3;  // phase + freq[47:2]

  typedef logic [CMD_W-1:0]   cmd_word_t;
  typedef logic [FREQ_W-1:0]  freq_t;
  typedef logic [AMP_W-1:0]   amp_t;
  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } seq_state_e;

  function automatic cmd_word_t pack_fap(amp_t amp, phase_t ph, freq_t f);
    return {DDS_SEL_FAP, amp, ph, f[47:16]};
  endfunction

  function automatic cmd_word_t pack_f48(freq_t f);
    return {DDS_SEL_F48, 12'h000, f};
  endfunction

  function automatic cmd_word_t pack_af(amp_t amp, freq_t f);
    return {DDS_SEL_AF, amp, f[47:2]};
  endfunction

  function automatic cmd_word_t pack_pf(phase_t ph, freq_t f);
    return {DDS_SEL_PF, ph, f[47:2]};
  endfunction

endpackage

// File: rtl/dds_cmd_planner.sv
// dds_cmd_planner: combinational word-list planner.
// Maps one update request plus the current shadow frequency onto the shortest
// list of DDS command words that applies it.
//   mask_i    {freq_en, amp_en, phase_en}
//   freq_i / amp_i / phase_i   request fields
//   shadow_i  frequency last issued to the DDS
//   words_o   packed word list, slot 0 first; unused slots are zero
//   count_o   number of valid slots (0..3)
//   freq_o    effective frequency F for this request (new shadow value)
module dds_cmd_planner
  import dds_cmd_pkg::*;
(
  input  logic [2:0]                  mask_i,
  input  freq_t                       freq_i,
  input  amp_t                        amp_i,
  input  phase_t                      phase_i,
  input  freq_t                       shadow_i,
  output logic [MAX_WORDS-1:0][CMD_W-1:0] words_o,
  output logic [1:0]                  count_o,
  output freq_t                       freq_o
);

  logic      freq_en, amp_en, phase_en;
  freq_t     f_eff;
  logic      use_fap, need_f48;
  // One spare slot so the running slot index never leaves the array.
  cmd_word_t slot [MAX_WORDS+1];
  logic [1:0] n;

  assign {freq_en, amp_en, phase_en} = mask_i;
  assign f_eff = freq_en ? freq_i : shadow_i;

  // FAP only rewrites freq[47:16]; it is usable alone when the low 16 bits
  // already match what the DDS holds.
  assign use_fap  = amp_en & phase_en & (f_eff[15:0] == shadow_i[15:0]);
  // AF/PF carry freq[47:2], so a full F48 is only needed when the two LSBs
  // move, or when nothing else would carry the new frequency.
  assign need_f48 = freq_en & ((f_eff[1:0] != shadow_i[1:0]) | (~amp_en & ~phase_en));

  always_comb begin
    for (int i = 0; i <= MAX_WORDS; i++) slot[i] = '0;
    n = 2'd0;
    if (mask_i == 3'b000) begin
      n = 2'd0;
    end else if (use_fap) begin
      slot[0] = pack_fap(amp_i, phase_i, f_eff);
      n       = 2'd1;
    end else begin
      if (need_f48) begin
        slot[n] = pack_f48(f_eff);
        n       = n + 2'd1;
      end
      if (amp_en) begin
        slot[n] = pack_af(amp_i, f_eff);
        n       = n + 2'd1;
      end
      if (phase_en) begin
        slot[n] = pack_pf(phase_i, f_eff);
        n       = n + 2'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < MAX_WORDS; i++) words_o[i] = slot[i];
  end

  assign count_o = n;
  assign freq_o  = f_eff;

endmodule

// File: rtl/dds_update_sequencer.sv
// dds_update_sequencer: turns one DDS update request (any subset of freq /
// amp / phase) into the shortest legal stream of 64-bit command words.
//   CLK100MHZ, reset      clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready only in IDLE
//   req_mask              {freq_en, amp_en, phase_en}
//   req_freq/amp/phase    request fields
//   cmd_data/valid/ready  command word stream towards the GPO path
//   done                  one-cycle pulse once a request is fully issued
//   shadow_clear          zero the frequency shadow (DDS reset externally)
//   shadow_freq           frequency last committed to the DDS
// Words of one sequence are separated by GAP_CYCLES idle cycles; the same gap
// follows the last word before a new request is taken.
module dds_update_sequencer
  import dds_cmd_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int GAP_W      = 8
) (
  input  logic               CLK100MHZ,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_mask,
  input  logic [FREQ_W-1:0]  req_freq,
  input  logic [AMP_W-1:0]   req_amp,
  input  logic [PHASE_W-1:0] req_phase,
  output logic [CMD_W-1:0]   cmd_data,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               done,
  input  logic               shadow_clear,
  output logic [FREQ_W-1:0]  shadow_freq
);

  localparam logic [GAP_W-1:0] GAP_LOAD =
    GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  seq_state_e                     state_q, state_d;
  logic [MAX_WORDS-1:0][CMD_W-1:0] words_q, words_d;
  logic [1:0]                     count_q, count_d;
  logic [1:0]                     idx_q, idx_d;
  logic [GAP_W-1:0]               gap_q, gap_d;
  logic                           done_q, done_d;
  freq_t                          shadow_q, shadow_d;

  logic [MAX_WORDS-1:0][CMD_W-1:0] plan_words;
  logic [1:0]                     plan_count;
  freq_t                          plan_freq;
  logic [1:0]                     idx_nxt;
  cmd_word_t                      cur_word;

  dds_cmd_planner u_planner (
    .mask_i   (req_mask),
    .freq_i   (req_freq),
    .amp_i    (req_amp),
    .phase_i  (req_phase),
    .shadow_i (shadow_q),
    .words_o  (plan_words),
    .count_o  (plan_count),
    .freq_o   (plan_freq)
  );

  assign idx_nxt = idx_q + 2'd1;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q  <= IDLE;
      words_q  <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      words_q  <= words_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    words_d  = words_q;
    count_d  = count_q;
    idx_d    = idx_q;
    gap_d    = gap_q;
    done_d   = 1'b0;
    shadow_d = shadow_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          shadow_d = plan_freq;
          words_d  = plan_words;
          count_d  = plan_count;
          idx_d    = 2'd0;
          if (plan_count == 2'd0) done_d  = 1'b1;
          else                    state_d = EMIT;
        end
      end
      EMIT: begin
        if (cmd_ready) begin
          // idx runs one past the last word; GAP uses idx==count to know
          // whether it is the inter-word gap or the trailing one.
          idx_d = idx_nxt;
          if (idx_nxt == count_q) begin
            done_d  = 1'b1;
            state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            state_d = (GAP_CYCLES > 0) ? GAP : EMIT;
          end
          gap_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = (idx_q == count_q) ? IDLE : EMIT;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over the accept-time update; queued words keep their F.
    if (shadow_clear) shadow_d = '0;
  end

  always_comb begin
    case (idx_q)
      2'd0:    cur_word = words_q[0];
      2'd1:    cur_word = words_q[1];
      2'd2:    cur_word = words_q[2];
      default: cur_word = '0;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign cmd_valid   = (state_q == EMIT);
  assign cmd_data    = cmd_valid ? cur_word : '0;
  assign done        = done_q;
  assign shadow_freq = shadow_q;

endmodule

// File: tb/tb_dds_update_sequencer.sv
module tb_dds_update_sequencer;

  localparam int GAP = 2;

  logic        CLK100MHZ = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_mask;
  logic [47:0] req_freq;
  logic [13:0] req_amp;
  logic [13:0] req_phase;
  logic [63:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        done;
  logic        shadow_clear;
  logic [47:0] shadow_freq;

  int n_chk = 0;
  int n_err = 0;

  logic [47:0] shadow_m;
  logic [63:0] exp_q [$];

  always #5 CLK100MHZ = ~CLK100MHZ;

  dds_update_sequencer #(.GAP_CYCLES(GAP), .GAP_W(8)) dut (
    .CLK100MHZ    (CLK100MHZ),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_mask     (req_mask),
    .req_freq     (req_freq),
    .req_amp      (req_amp),
    .req_phase    (req_phase),
    .cmd_data     (cmd_data),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .done         (done),
    .shadow_clear (shadow_clear),
    .shadow_freq  (shadow_freq)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the word list the update needs, straight from the word rules.
  task automatic model_plan(input logic [2:0] m, input logic [47:0] f, input logic [13:0] a,
                            input logic [13:0] p, input logic [47:0] s);
    logic [47:0] F;
    F = m[2] ? f : s;
    exp_q.delete();
    if (m == 3'b000) return;
    if (m[1] && m[0] && F[15:0] == s[15:0]) begin
      exp_q.push_back({4'h0, a, p, F[47:16]});
      return;
    end
    if (m[2] && (F[1:0] != s[1:0] || m[1:0] == 2'b00)) exp_q.push_back({4'h1, 12'h000, F});
    if (m[1]) exp_q.push_back({4'h2, a, F[47:2]});
    if (m[0]) exp_q.push_back({4'h3, p, F[47:2]});
  endtask

  task automatic scramble_req();
    req_mask  = 3'($urandom);
    req_freq  = {16'($urandom), $urandom};
    req_amp   = 14'($urandom);
    req_phase = 14'($urandom);
  endtask

  task automatic accept(input logic [2:0] m, input logic [47:0] f, input logic [13:0] a,
                        input logic [13:0] p, input bit clr);
    int n;
    n = 0;
    while (!req_ready && n < 64) begin @(negedge CLK100MHZ); n++; end
    chk("req_ready_wait", {63'd0, req_ready}, 64'd1);
    model_plan(m, f, a, p, shadow_m);
    shadow_m = clr ? 48'd0 : (m[2] ? f : shadow_m);
    req_valid = 1'b1; req_mask = m; req_freq = f; req_amp = a; req_phase = p;
    shadow_clear = clr;
    @(negedge CLK100MHZ);
    req_valid = 1'b0; shadow_clear = 1'b0;
    scramble_req();
    chk("shadow_after_accept", {16'd0, shadow_freq}, {16'd0, shadow_m});
  endtask

  // stall >= 0: hold cmd_ready low that many cycles per word; stall < 0: random.
  task automatic do_req(input logic [2:0] m, input logic [47:0] f, input logic [13:0] a,
                        input logic [13:0] p, input int stall, input bit clr);
    int idx, wc, lows, tmo;
    bit rdy;
    accept(m, f, a, p, clr);
    if (exp_q.size() == 0) begin
      chk("empty_done", {63'd0, done}, 64'd1);
      chk("empty_valid", {63'd0, cmd_valid}, 64'd0);
      chk("empty_ready", {63'd0, req_ready}, 64'd1);
      @(negedge CLK100MHZ);
      chk("empty_done_pulse", {63'd0, done}, 64'd0);
      chk("empty_valid2", {63'd0, cmd_valid}, 64'd0);
      return;
    end
    chk("first_valid", {63'd0, cmd_valid}, 64'd1);
    idx = 0; wc = 0; lows = 0; tmo = 0;
    while (idx < exp_q.size() && tmo < 500) begin
      chk("done_mid", {63'd0, done}, 64'd0);
      if (cmd_valid) begin
        chk("word", cmd_data, exp_q[idx]);
        if (idx > 0 && wc == 0) chk("gap_len", 64'(lows), 64'(GAP));
        rdy = (stall < 0) ? 1'($urandom_range(0, 1)) : (wc >= stall);
        cmd_ready = rdy;
        wc++;
        @(negedge CLK100MHZ);
        if (rdy) begin idx++; wc = 0; lows = 0; end
      end else begin
        chk("gap_ready_low", {63'd0, req_ready}, 64'd0);
        lows++;
        cmd_ready = 1'($urandom);
        @(negedge CLK100MHZ);
      end
      tmo++;
    end
    chk("seq_timeout", {63'd0, tmo < 500}, 64'd1);
    cmd_ready = 1'b0;
    chk("last_done", {63'd0, done}, 64'd1);
    chk("last_valid", {63'd0, cmd_valid}, 64'd0);
    chk("last_ready", {63'd0, req_ready}, {63'd0, GAP == 0});
    for (int k = 1; k <= GAP; k++) begin
      @(negedge CLK100MHZ);
      chk("tail_done", {63'd0, done}, 64'd0);
      chk("tail_valid", {63'd0, cmd_valid}, 64'd0);
      chk("tail_ready", {63'd0, req_ready}, {63'd0, k == GAP});
    end
    chk("shadow_end", {16'd0, shadow_freq}, {16'd0, shadow_m});
  endtask

  initial begin
    logic [2:0]  m;
    logic [47:0] f;
    int n;
    reset = 1'b1; req_valid = 1'b0; cmd_ready = 1'b0; shadow_clear = 1'b0;
    scramble_req();
    shadow_m = '0;
    repeat (3) @(negedge CLK100MHZ);
    reset = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_cmd_valid", {63'd0, cmd_valid}, 64'd0);
    chk("rst_cmd_data", cmd_data, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_shadow", {16'd0, shadow_freq}, 64'd0);

    // Directed sequence
    do_req(3'b111, 48'h1234_5678_0000, 14'h3FFF, 14'h0100, 0, 1'b0);
    do_req(3'b100, 48'hABCD_EF01_2345, 14'h0000, 14'h0000, 0, 1'b0);
    do_req(3'b010, 48'h0, 14'h0010, 14'h0000, 0, 1'b0);
    do_req(3'b111, 48'h0000_0000_0003, 14'h1555, 14'h2AAA, 5, 1'b0);

    // Reset while the 2nd of 3 words is pending
    accept(3'b111, 48'h0000_0000_1234, 14'h0123, 14'h0456, 1'b0);
    chk("rst_seq_len", 64'(exp_q.size()), 64'd3);
    cmd_ready = 1'b1;
    @(negedge CLK100MHZ);
    cmd_ready = 1'b0;
    n = 0;
    while (!cmd_valid && n < 16) begin @(negedge CLK100MHZ); n++; end
    chk("rst_w1_pending", cmd_data, exp_q[1]);
    reset = 1'b1;
    @(negedge CLK100MHZ);
    reset = 1'b0;
    shadow_m = '0;
    chk("midrst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("midrst_shadow", {16'd0, shadow_freq}, 64'd0);
    chk("midrst_ready", {63'd0, req_ready}, 64'd1);
    chk("midrst_done", {63'd0, done}, 64'd0);
    @(negedge CLK100MHZ);
    chk("midrst_done2", {63'd0, done}, 64'd0);
    chk("midrst_valid2", {63'd0, cmd_valid}, 64'd0);

    do_req(3'b000, 48'h0, 14'h0, 14'h0, 0, 1'b0);
    do_req(3'b100, 48'h0000_7777_8889, 14'h0, 14'h0, 0, 1'b0);
    do_req(3'b100, 48'hFEDC_BA98_7654, 14'h0, 14'h0, 0, 1'b1);

    // Random requests, biased to hit the FAP-only and LSB-match cases
    for (int it = 0; it < 40; it++) begin
      m = 3'($urandom);
      f = {16'($urandom), $urandom};
      case ($urandom_range(0, 2))
        0: f[15:0] = shadow_m[15:0];
        1: f[1:0]  = shadow_m[1:0];
        default: ;
      endcase
      do_req(m, f, 14'($urandom), 14'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
             ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/dds_update_sequencer.md
Name: dds_update_sequencer

Overview:
- Accepts one high-level DDS update request: any subset of {48-bit freq, 14-bit amp, 14-bit phase}.
- Emits the shortest legal sequence of 64-bit DDS command words, each {4-bit dest sel, 60-bit data}, over a valid/ready stream.
- Sits upstream of the DDS controller's GPO command path (timestamp/FIFO logic).
- Keeps a shadow of the last issued frequency, so partial updates never corrupt the untouched frequency bits.

Parameters:
- GAP_CYCLES, 2, idle cycles with cmd_valid low between consecutive words of one sequence; 0 means back-to-back.
- GAP_W, 8, width of the gap counter; GAP_CYCLES must be below 2**GAP_W.

Ports:
- CLK100MHZ  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_mask  in  3  {freq_en, amp_en, phase_en}.
- req_freq  in  48  new frequency word.
- req_amp  in  14  new amplitude (unsigned).
- req_phase  in  14  new phase.
- cmd_data  out  64  command word.
- cmd_valid  out  1  cmd_data valid.
- cmd_ready  in  1  downstream accepts the word.
- done  out  1  one-cycle pulse when a request is fully issued.
- shadow_clear  in  1  forces shadow freq to 0; use when the DDS is reset externally.
- shadow_freq  out  48  current shadow frequency.

Behaviour:
- Clock and reset: one clock (CLK100MHZ); reset is synchronous and active-high.
- Reset values: req_ready=1, cmd_valid=0, cmd_data=0, done=0, shadow_freq=0; FSM goes to IDLE, gap counter to 0.
- FSM states: IDLE, EMIT, GAP.
- req_ready is 1 only in IDLE. A request is accepted when req_valid&req_ready.
- At accept (cycle T):
  - F = freq_en ? req_freq : shadow_freq.
  - shadow_freq <= F.
  - Build a word list of 0..3 entries in registers, plus a count.
- Word formats:
  - W0 = {4'h0, amp, phase, F[47:16]}
  - W1 = {4'h1, 12'h0, F}
  - W2 = {4'h2, amp, F[47:2]}
  - W3 = {4'h3, phase, F[47:2]}
  - amp and phase are the request values.
- Selection rules, with S = shadow_freq before accept:
  - mask 000: empty list.
  - amp_en&phase_en and F[15:0]==S[15:0]: W0 only.
  - Otherwise, in this order:
    - W1 if freq_en and (F[1:0]!=S[1:0] or (!amp_en and !phase_en)).
    - W2 if amp_en.
    - W3 if phase_en.
  - Example: mask 100 gives W1 only.
  - Example: mask 110 with F[1:0]==S[1:0] gives W2 only.
- Empty list: done=1 at T+1; FSM stays in IDLE.
- Non-empty list: go to EMIT; cmd_valid=1 with word 0 at T+1.
- EMIT:
  - cmd_data and cmd_valid are held stable until cmd_ready.
  - On handshake with words remaining: GAP_CYCLES>0 goes to GAP with cmd_valid=0; GAP_CYCLES==0 presents the next word the following cycle (cmd_valid stays 1).
- GAP: count GAP_CYCLES cycles, then return to EMIT with the next word.
- Last handshake (cycle L):
  - cmd_valid=0 and done=1 at L+1.
  - With GAP_CYCLES>0, enter GAP, then IDLE; req_ready=1 at L+1+GAP_CYCLES.
  - With GAP_CYCLES==0, go to IDLE; req_ready=1 at L+1.
- Throughput: with cmd_ready always 1, successive words of one sequence are GAP_CYCLES+1 cycles apart.
- shadow_clear:
  - Honoured in any state; takes priority over the shadow update at accept in the same cycle.
  - Does not alter words already queued.
- Reset mid-sequence: the remaining words are dropped, no done pulse, all state returns to reset values the next cycle.
- req inputs are ignored while req_ready=0.
- cmd_ready while cmd_valid=0 has no effect.

Decomposition:
- Package dds_cmd_pkg:
  - Dest-sel constants DDS_SEL_FAP=4'h0, DDS_SEL_F48=4'h1, DDS_SEL_AF=4'h2, DDS_SEL_PF=4'h3.
  - Field widths FREQ_W=48, AMP_W=14, PHASE_W=14.
  - FSM state enum.
  - Word-packing functions.
- One sub-module: dds_cmd_planner. Combinational; maps (mask, req fields, shadow) to (word list, count).

Test Plan:
- Reset; mask 111, freq 48'h1234_5678_0000, amp 14'h3FFF, phase 14'h0100 -> single word 64'h0FFF_C100_1234_5678, done one cycle after the handshake.
- Then mask 100, freq 48'hABCD_EF01_2345 -> single word 64'h1000_ABCD_EF01_2345; shadow_freq=48'hABCD_EF01_2345.
- Then mask 010, amp 14'h0010 -> single word 64'h2004_2AF3_7BC0_48D1.
- Then mask 111, freq 48'h0000_0000_0003, cmd_ready low for 5 cycles on each word:
  - Expect W1, W2, W3 in order.
  - Each word stable while stalled.
  - Exactly 2 cmd_valid-low cycles between words.
  - req_ready low until 2 cycles after done.
- Reset asserted while the 2nd of 3 words is pending -> next cycle cmd_valid=0, shadow_freq=0, req_ready=1; no done pulse.
- mask 000 -> done at T+1, cmd_valid never asserted; shadow_clear together with accept of mask 100 -> shadow_freq=0 afterwards.
